// File: rtl/ic_pkg.sv
// Shared interconnect types and constants for the VC scheduler slice.
// Word format and scheduler state encodings used by the VC/D FIFO path.
package ic_pkg;

    localparam int BW       = 6;
    localparam int DEST_BIT = 4;
    localparam int CRED_W   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VC0 = 2'd1,
        SERVE_VC1 = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        CRED_HOLD  = 2'd0,
        CRED_LOAD1 = 2'd1,
        CRED_INC   = 2'd2,
        CRED_CLEAR = 2'd3
    } cred_op_t;

endpackage

// File: rtl/wrr_credit.sv
// Consecutive-grant credit register for the WRR scheduler.
// Saturates at the active weight; cred_lt_w tells the FSM it may keep serving.
module wrr_credit
    import ic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  cred_op_t          op,
    input  logic [CRED_W-1:0] weight,
    output logic              cred_lt_w
);

    logic [CRED_W-1:0] cred;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cred <= '0;
        end else begin
            case (op)
                CRED_LOAD1: cred <= CRED_W'(1);
                CRED_INC:   cred <= (cred < weight) ? cred + CRED_W'(1) : weight;
                CRED_CLEAR: cred <= '0;
                default:    cred <= cred;
            endcase
        end
    end

    assign cred_lt_w = (cred < weight);

endmodule

// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin pop scheduler between the VC0/VC1 FIFOs and demux_dest.
// Pops are combinational; the popped word is presented registered one cycle later.
module vc_wrr_scheduler
    import ic_pkg::*;
#(
    parameter int W0    = 3,
    parameter int W1    = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arb_enable,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic [BW-1:0]    VC0_data_out,
    input  logic [BW-1:0]    VC1_data_out,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    output logic             VC0_rd,
    output logic             VC1_rd,
    output logic             demux_dest_valid_in,
    output logic [BW-1:0]    demux_dest_data_in,
    output logic [CNT_W-1:0] vc0_grant_cnt,
    output logic [CNT_W-1:0] vc1_grant_cnt
);

    localparam logic [CRED_W-1:0] W0_L = CRED_W'(W0);
    localparam logic [CRED_W-1:0] W1_L = CRED_W'(W1);

    sched_state_t      state, state_nx;
    cred_op_t          cred_op;
    logic              cred_lt_w;
    logic [CRED_W-1:0] weight;
    logic              elig0, elig1;
    logic              pop0, pop1;

    // Each VC only checks the destination its own head word targets.
    assign elig0 = arb_enable & ~VC0_empty &
                   ~(VC0_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);
    assign elig1 = arb_enable & ~VC1_empty &
                   ~(VC1_data_out[DEST_BIT] ? D1_almost_full : D0_almost_full);

    assign weight = (state == SERVE_VC1) ? W1_L : W0_L;

    wrr_credit u_credit (
        .clk       (clk),
        .reset     (reset),
        .op        (cred_op),
        .weight    (weight),
        .cred_lt_w (cred_lt_w)
    );

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        pop0     = 1'b0;
        pop1     = 1'b0;
        state_nx = state;
        cred_op  = CRED_HOLD;
        if (!reset && arb_enable) begin
            case (state)
                IDLE: begin
                    if (elig0) begin
                        pop0 = 1'b1; state_nx = SERVE_VC0; cred_op = CRED_LOAD1;
                    end else if (elig1) begin
                        pop1 = 1'b1; state_nx = SERVE_VC1; cred_op = CRED_LOAD1;
                    end
                end
                SERVE_VC0: begin
                    if (elig0 && (cred_lt_w || !elig1)) begin
                        pop0 = 1'b1; cred_op = CRED_INC;
                    end else if (elig1) begin
                        pop1 = 1'b1; state_nx = SERVE_VC1; cred_op = CRED_LOAD1;
                    end else begin
                        state_nx = IDLE; cred_op = CRED_CLEAR;
                    end
                end
                SERVE_VC1: begin
                    if (elig1 && (cred_lt_w || !elig0)) begin
                        pop1 = 1'b1; cred_op = CRED_INC;
                    end else if (elig0) begin
                        pop0 = 1'b1; state_nx = SERVE_VC0; cred_op = CRED_LOAD1;
                    end else begin
                        state_nx = IDLE; cred_op = CRED_CLEAR;
                    end
                end
                default: begin
                    state_nx = IDLE; cred_op = CRED_CLEAR;
                end
            endcase
        end
    end

    assign VC0_rd = pop0;
    assign VC1_rd = pop1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            demux_dest_valid_in <= 1'b0;
            demux_dest_data_in  <= '0;
            vc0_grant_cnt       <= '0;
            vc1_grant_cnt       <= '0;
        end else begin
            state               <= state_nx;
            demux_dest_valid_in <= pop0 | pop1;
            if (pop0)
                demux_dest_data_in <= VC0_data_out;
            else if (pop1)
                demux_dest_data_in <= VC1_data_out;
            if (pop0) vc0_grant_cnt <= vc0_grant_cnt + CNT_W'(1);
            if (pop1) vc1_grant_cnt <= vc1_grant_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Directed bench for vc_wrr_scheduler: vector table from IDLE plus multi-cycle sequences
// driven from queue models of the VC FIFOs.
module tb_vc_wrr_scheduler;
    import ic_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          arb_enable;
    logic          VC0_empty, VC1_empty;
    logic [BW-1:0] VC0_data_out, VC1_data_out;
    logic          D0_almost_full, D1_almost_full;
    logic          VC0_rd, VC1_rd;
    logic          demux_dest_valid_in;
    logic [BW-1:0] demux_dest_data_in;
    logic [15:0]   vc0_grant_cnt, vc1_grant_cnt;

    vc_wrr_scheduler #(.W0(3), .W1(1), .CNT_W(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .arb_enable          (arb_enable),
        .VC0_empty           (VC0_empty),
        .VC1_empty           (VC1_empty),
        .VC0_data_out        (VC0_data_out),
        .VC1_data_out        (VC1_data_out),
        .D0_almost_full      (D0_almost_full),
        .D1_almost_full      (D1_almost_full),
        .VC0_rd              (VC0_rd),
        .VC1_rd              (VC1_rd),
        .demux_dest_valid_in (demux_dest_valid_in),
        .demux_dest_data_in  (demux_dest_data_in),
        .vc0_grant_cnt       (vc0_grant_cnt),
        .vc1_grant_cnt       (vc1_grant_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];
    logic          exp_valid;
    logic [BW-1:0] exp_data;
    logic [15:0]   exp_cnt0, exp_cnt1;

    typedef struct packed {
        logic          en;
        logic          emp0;
        logic          emp1;
        logic [BW-1:0] w0;
        logic [BW-1:0] w1;
        logic          af0;
        logic          af1;
        logic          rd0;
        logic          rd1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_vcs();
        VC0_empty    = (q0.size() == 0);
        VC1_empty    = (q1.size() == 0);
        VC0_data_out = VC0_empty ? '0 : q0[0];
        VC1_data_out = VC1_empty ? '0 : q1[0];
    endtask

    // One clock with the queue-backed FIFOs; e0/e1 are the expected pops this cycle.
    task automatic tick(input logic e0, input logic e1, input string name);
        logic          r0, r1;
        logic [BW-1:0] h0, h1;
        drive_vcs();
        #1;
        check({name, " VC0_rd"}, 32'(VC0_rd), 32'(e0));
        check({name, " VC1_rd"}, 32'(VC1_rd), 32'(e1));
        check({name, " rd exclusive"}, 32'(VC0_rd & VC1_rd), 32'd0);
        check({name, " rd while empty"}, 32'((VC0_rd & VC0_empty) | (VC1_rd & VC1_empty)), 32'd0);
        r0 = VC0_rd;
        r1 = VC1_rd;
        h0 = VC0_data_out;
        h1 = VC1_data_out;
        @(posedge clk);
        #1;
        if (r0 && q0.size() > 0) void'(q0.pop_front());
        if (r1 && q1.size() > 0) void'(q1.pop_front());
        if (reset) begin
            exp_valid = 1'b0; exp_data = '0; exp_cnt0 = '0; exp_cnt1 = '0;
        end else begin
            exp_valid = e0 | e1;
            if (e0)      exp_data = h0;
            else if (e1) exp_data = h1;
            if (e0) exp_cnt0 = exp_cnt0 + 16'd1;
            if (e1) exp_cnt1 = exp_cnt1 + 16'd1;
        end
        check({name, " valid"}, 32'(demux_dest_valid_in), 32'(exp_valid));
        check({name, " data"},  32'(demux_dest_data_in),  32'(exp_data));
        check({name, " cnt0"},  32'(vc0_grant_cnt),       32'(exp_cnt0));
        check({name, " cnt1"},  32'(vc1_grant_cnt),       32'(exp_cnt1));
        drive_vcs();
    endtask

    task automatic do_reset(input string name);
        reset = 1'b1;
        tick(1'b0, 1'b0, name);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arb_enable = 1'b1;
        D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        exp_valid = 1'b0; exp_data = '0; exp_cnt0 = '0; exp_cnt1 = '0;
        drive_vcs();
        do_reset("init reset");

        // en, emp0, emp1, w0, w1, af0, af1, rd0, rd1 -- all applied from IDLE
        vecs[0] = '{1'b1, 1'b0, 1'b0, 6'h05, 6'h09, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 6'h05, 6'h09, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 6'h00, 6'h12, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 6'h13, 6'h02, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 6'h07, 6'h02, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'h0A, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            logic [BW-1:0] wexp;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            arb_enable     = vecs[i].en;
            VC0_empty      = vecs[i].emp0;
            VC1_empty      = vecs[i].emp1;
            VC0_data_out   = vecs[i].w0;
            VC1_data_out   = vecs[i].w1;
            D0_almost_full = vecs[i].af0;
            D1_almost_full = vecs[i].af1;
            #1;
            check($sformatf("vec%0d VC0_rd", i), 32'(VC0_rd), 32'(vecs[i].rd0));
            check($sformatf("vec%0d VC1_rd", i), 32'(VC1_rd), 32'(vecs[i].rd1));
            wexp = vecs[i].rd0 ? vecs[i].w0 : (vecs[i].rd1 ? vecs[i].w1 : '0);
            @(posedge clk); #1;
            check($sformatf("vec%0d valid", i), 32'(demux_dest_valid_in), 32'(vecs[i].rd0 | vecs[i].rd1));
            check($sformatf("vec%0d data", i),  32'(demux_dest_data_in),  32'(wexp));
        end
        arb_enable = 1'b1; D0_almost_full = 1'b0; D1_almost_full = 1'b0;
        exp_cnt0 = '0; exp_cnt1 = '0;
        do_reset("post-vector reset");

        // Single eligible VC: six back-to-back pops, no bubbles.
        for (int i = 0; i < 6; i++) q0.push_back(BW'(6'h20 + i));
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, $sformatf("solo vc0 #%0d", i));
        tick(1'b0, 1'b0, "solo drained");
        check("solo cnt0 total", 32'(vc0_grant_cnt), 32'd6);

        // Both VCs backlogged: pattern 0,0,0,1 repeating with W0=3, W1=1.
        do_reset("wrr reset");
        for (int i = 0; i < 8; i++) begin
            q0.push_back(BW'(i));
            q1.push_back(BW'(8 + i));
        end
        for (int i = 0; i < 8; i++)
            tick(i % 4 != 3, i % 4 == 3, $sformatf("wrr #%0d", i));
        check("wrr cnt0 total", 32'(vc0_grant_cnt), 32'd6);
        check("wrr cnt1 total", 32'(vc1_grant_cnt), 32'd2);
        q0.delete(); q1.delete();

        // Per-VC head-of-line: VC0 head targets a full D1, VC1 keeps flowing.
        do_reset("hol reset");
        q0.push_back(6'h15); q0.push_back(6'h06);
        q1.push_back(6'h03); q1.push_back(6'h04);
        D1_almost_full = 1'b1;
        tick(1'b0, 1'b1, "hol vc1 a");
        tick(1'b0, 1'b1, "hol vc1 b");
        tick(1'b0, 1'b0, "hol stalled");
        D1_almost_full = 1'b0;
        tick(1'b1, 1'b0, "hol release");
        tick(1'b1, 1'b0, "hol vc0 next");
        q0.delete(); q1.delete();

        // arb_enable low in SERVE_VC0 with cred=2 freezes state and credit.
        do_reset("en reset");
        for (int i = 0; i < 6; i++) q0.push_back(BW'(6'h28 + i));
        for (int i = 0; i < 4; i++) q1.push_back(BW'(6'h08 + i));
        tick(1'b1, 1'b0, "en pop1");
        tick(1'b1, 1'b0, "en pop2");
        arb_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, $sformatf("en off #%0d", i));
        arb_enable = 1'b1;
        tick(1'b1, 1'b0, "en resume vc0");
        tick(1'b0, 1'b1, "en yield vc1");

        // Reset mid-traffic: two cycles, no pops, outputs and counters cleared.
        reset = 1'b1;
        tick(1'b0, 1'b0, "midrst a");
        tick(1'b0, 1'b0, "midrst b");
        reset = 1'b0;
        tick(1'b1, 1'b0, "midrst restart");
        q0.delete(); q1.delete();

        // Counter wrap from all-ones.
        do_reset("wrap reset");
        q0.push_back(6'h11);
        force dut.vc0_grant_cnt = 16'hFFFF;
        #1;
        release dut.vc0_grant_cnt;
        exp_cnt0 = 16'hFFFF;
        tick(1'b1, 1'b0, "wrap pop");
        check("wrap cnt0 zero", 32'(vc0_grant_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
